// File: rtl/iter_divider.sv
// iter_divider: multicycle signed restoring divider, one quotient bit per clock.
// Define DIV_REMAINDER_EN to add the data_remainder output.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   b_abs;
  logic [CW-1:0]    cnt;
  logic             sign_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH:0]   b_abs_in;
  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;

  // An unsigned WIDTH-bit |A| still represents 2^(WIDTH-1), so INT_MIN needs no special case.
  assign a_abs    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_abs_in = {1'b0, (data_operandB[WIDTH-1] ? -data_operandB : data_operandB)};
  assign r_shift  = {r, q[WIDTH-1]};
  assign trial    = r_shift - {1'b0, b_abs};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A start pulse in any state aborts whatever is in flight and reloads.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_DIV) state_next = LOAD;
      LOAD:    state_next = (b_abs == '0) ? DONE : RUN;
      RUN:     if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (ctrl_DIV) state_next = LOAD;
  end

  always_comb begin
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state)
      LOAD, RUN, FIX: busy = 1'b1;
      DONE:           data_resultRDY = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q              <= '0;
      r              <= '0;
      b_abs          <= '0;
      cnt            <= '0;
      sign_q         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      q              <= a_abs;
      r              <= '0;
      b_abs          <= b_abs_in;
      cnt            <= CW'(WIDTH);
      sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      data_exception <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (b_abs == '0) begin
            data_exception <= 1'b1;
            data_result    <= '0;
          end
        end
        RUN: begin
          if (!trial[WIDTH+1]) begin
            r <= trial[WIDTH:0];
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            r <= r_shift[WIDTH:0];
            q <= {q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        FIX:     data_result <= sign_q ? -q : q;
        default: ;
      endcase
    end
  end

`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] a_raw;

  // Remainder takes the dividend's sign so that A = Q*B + rem holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_raw          <= '0;
      data_remainder <= '0;
    end else if (ctrl_DIV) begin
      a_raw <= data_operandA;
    end else begin
      case (state)
        LOAD:    if (b_abs == '0) data_remainder <= a_raw;
        FIX:     data_remainder <= a_raw[WIDTH-1] ? -r[WIDTH-1:0] : r[WIDTH-1:0];
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: scoreboard-driven self-checking bench for iter_divider.
// Remainder checks are compiled in when DIV_REMAINDER_EN is defined.
module tb_iter_divider;
  localparam int WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] data_remainder;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] rem;
    logic        exc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  iter_divider #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy(busy)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder(data_remainder)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference in 64-bit arithmetic so INT_MIN / -1 cannot overflow the model itself.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint da, dv, qq, rr;
    if (b == 32'd0) begin
      e.q = 32'd0; e.rem = a; e.exc = 1'b1; e.lat = 1;
    end else begin
      da = longint'($signed(a));
      dv = longint'($signed(b));
      qq = da / dv;
      rr = da % dv;
      e.q = qq[31:0]; e.rem = rr[31:0]; e.exc = 1'b0; e.lat = WIDTH + 2;
    end
    return e;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic push);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(output int edges);
    edges = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_DIV = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (3) @(negedge clock);
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (data_resultRDY !== 1'b0) $display("[TB] FAIL reset_rdy got %b want 0", data_resultRDY); else passed++;
    total++; if (data_result !== 32'd0) $display("[TB] FAIL reset_result got %h want 0", data_result); else passed++;
    total++; if (data_exception !== 1'b0) $display("[TB] FAIL reset_exc got %b want 0", data_exception); else passed++;
`ifdef DIV_REMAINDER_EN
    total++; if (data_remainder !== 32'd0) $display("[TB] FAIL reset_rem got %h want 0", data_remainder); else passed++;
`endif
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_arith();
    logic [31:0] ta [12];
    logic [31:0] tb [12];
    exp_t e;
    int lat;
    ta[0] = 32'd100;       tb[0] = 32'd7;
    ta[1] = 32'hFFFFFF9C;  tb[1] = 32'd7;
    ta[2] = 32'hFFFFFF9C;  tb[2] = 32'hFFFFFFF9;
    ta[3] = 32'd100;       tb[3] = 32'hFFFFFFF9;
    ta[4] = 32'h80000000;  tb[4] = 32'hFFFFFFFF;
    ta[5] = 32'h80000000;  tb[5] = 32'd1;
    ta[6] = 32'h7FFFFFFF;  tb[6] = 32'h80000000;
    ta[7] = 32'd3;         tb[7] = 32'd10;
    for (int i = 8; i < 12; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom_range(1, 100000);
      if ($urandom_range(0, 1) == 1) tb[i] = ~tb[i] + 32'd1;
    end
    for (int i = 0; i < 12; i++) begin
      start_op(ta[i], tb[i], 1'b1);
      total++; if (busy !== 1'b1) $display("[TB] FAIL arith_busy[%0d] got %b want 1", i, busy); else passed++;
      wait_rdy(lat);
      e = sb.pop_front();
      total++; if (lat != e.lat) $display("[TB] FAIL arith_latency[%0d] got %0d want %0d", i, lat, e.lat); else passed++;
      total++; if (data_result !== e.q) $display("[TB] FAIL arith_result[%0d] a=%h b=%h got %h want %h", i, ta[i], tb[i], data_result, e.q); else passed++;
      total++; if (data_exception !== e.exc) $display("[TB] FAIL arith_exc[%0d] got %b want %b", i, data_exception, e.exc); else passed++;
`ifdef DIV_REMAINDER_EN
      total++; if (data_remainder !== e.rem) $display("[TB] FAIL arith_rem[%0d] got %h want %h", i, data_remainder, e.rem); else passed++;
`endif
      @(negedge clock);
      total++; if (data_resultRDY !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL arith_pulse[%0d] rdy=%b busy=%b want 0/0", i, data_resultRDY, busy); else passed++;
      total++; if (data_result !== e.q) $display("[TB] FAIL arith_hold[%0d] got %h want %h", i, data_result, e.q); else passed++;
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    int lat;
    start_op(32'd5, 32'd0, 1'b1);
    wait_rdy(lat);
    e = sb.pop_front();
    total++; if (lat != 1) $display("[TB] FAIL dz_latency got %0d want 1", lat); else passed++;
    total++; if (data_exception !== 1'b1) $display("[TB] FAIL dz_exc got %b want 1", data_exception); else passed++;
    total++; if (data_result !== e.q) $display("[TB] FAIL dz_result got %h want %h", data_result, e.q); else passed++;
`ifdef DIV_REMAINDER_EN
    total++; if (data_remainder !== e.rem) $display("[TB] FAIL dz_rem got %h want %h", data_remainder, e.rem); else passed++;
`endif
    start_op(32'd9, 32'd3, 1'b1);
    wait_rdy(lat);
    e = sb.pop_front();
    total++; if (lat != e.lat) $display("[TB] FAIL dz_next_latency got %0d want %0d", lat, e.lat); else passed++;
    total++; if (data_result !== e.q) $display("[TB] FAIL dz_next_result got %h want %h", data_result, e.q); else passed++;
    total++; if (data_exception !== 1'b0) $display("[TB] FAIL dz_next_exc got %b want 0", data_exception); else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    int extra = 0;
    start_op(32'd50, 32'd5, 1'b0);
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) extra++;
    end
    start_op(32'd81, 32'd9, 1'b1);
    wait_rdy(lat);
    e = sb.pop_front();
    total++; if (lat != e.lat) $display("[TB] FAIL abort_latency got %0d want %0d", lat, e.lat); else passed++;
    total++; if (data_result !== e.q) $display("[TB] FAIL abort_result got %h want %h", data_result, e.q); else passed++;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) extra++;
    end
    total++; if (extra != 0) $display("[TB] FAIL abort_extra_rdy got %0d want 0", extra); else passed++;
  endtask

  task automatic test_done_restart();
    exp_t e;
    int lat;
    start_op(32'd20, 32'd4, 1'b1);
    wait_rdy(lat);
    e = sb.pop_front();
    total++; if (data_result !== e.q) $display("[TB] FAIL restart_first got %h want %h", data_result, e.q); else passed++;
    data_operandA = 32'd7;
    data_operandB = 32'd2;
    ctrl_DIV = 1'b1;
    sb.push_back(model(32'd7, 32'd2));
    @(negedge clock);
    ctrl_DIV = 1'b0;
    total++; if (busy !== 1'b1) $display("[TB] FAIL restart_busy got %b want 1", busy); else passed++;
    wait_rdy(lat);
    e = sb.pop_front();
    total++; if (lat != e.lat) $display("[TB] FAIL restart_latency got %0d want %0d", lat, e.lat); else passed++;
    total++; if (data_result !== e.q) $display("[TB] FAIL restart_result got %h want %h", data_result, e.q); else passed++;
`ifdef DIV_REMAINDER_EN
    total++; if (data_remainder !== e.rem) $display("[TB] FAIL restart_rem got %h want %h", data_remainder, e.rem); else passed++;
`endif
  endtask

  task automatic test_async_reset();
    exp_t e;
    int lat;
    int extra = 0;
    start_op(32'd100, 32'd3, 1'b0);
    repeat (14) @(negedge clock);
    total++; if (busy !== 1'b1) $display("[TB] FAIL areset_pre_busy got %b want 1", busy); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("[TB] FAIL areset_busy got %b want 0", busy); else passed++;
    total++; if (data_resultRDY !== 1'b0) $display("[TB] FAIL areset_rdy got %b want 0", data_resultRDY); else passed++;
    total++; if (data_result !== 32'd0) $display("[TB] FAIL areset_result got %h want 0", data_result); else passed++;
    @(negedge clock);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) extra++;
    end
    total++; if (extra != 0) $display("[TB] FAIL areset_extra_rdy got %0d want 0", extra); else passed++;
    start_op(32'd8, 32'd2, 1'b1);
    wait_rdy(lat);
    e = sb.pop_front();
    total++; if (lat != e.lat) $display("[TB] FAIL areset_next_latency got %0d want %0d", lat, e.lat); else passed++;
    total++; if (data_result !== e.q) $display("[TB] FAIL areset_next_result got %h want %h", data_result, e.q); else passed++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div_zero();
    test_back_to_back();
    test_done_restart();
    test_async_reset();
    total++; if (sb.size() != 0) $display("[TB] FAIL scoreboard_left got %0d want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
